// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control FSM.
// Contents: opcode constants, accumulator-source encodings, FSM state enum,
// PC-update kinds, and the packed control word produced by the decoder.
package bip_pkg;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_JMP  = 5'b01010;

  localparam logic [1:0] SEL_A_RAM     = 2'b00;
  localparam logic [1:0] SEL_A_OPERAND = 2'b01;
  localparam logic [1:0] SEL_A_ALU     = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_JMP = 2'd1,
    PC_BEQ = 2'd2,
    PC_BNE = 2'd3
  } pc_kind_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       write_acc;
    logic       operacion;
    logic       write_ram;
    logic       read_ram;
    pc_kind_t   pc_kind;
    logic       halt;
    logic       illegal;
  } ctrl_t;

  // All-zero word: no strobes, selects at 0, PC_INC, no halt.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/bip_control_fsm_if.sv
// Bus between the BIP controller and its program memory / datapath.
// master: controller side (reads instruction and flags, drives strobes/PC).
// slave : memory/datapath side (the opposite directions).
interface bip_control_fsm_if #(
  parameter int WORD_W   = 16,
  parameter int OPCODE_W = 5,
  parameter int ADDR_W   = WORD_W - OPCODE_W
);
  logic [WORD_W-1:0] i_instruction;
  logic              i_instr_valid;
  logic              i_acc_zero;
  logic [ADDR_W-1:0] o_operand;
  logic [1:0]        o_sel_a;
  logic              o_sel_b;
  logic              o_write_acc;
  logic              o_operacion;
  logic              o_write_ram;
  logic              o_read_ram;
  logic [ADDR_W-1:0] o_addr;
  logic              o_halted;
  logic              o_illegal;
  logic [31:0]       o_cycle_count;

  modport master (
    input  i_instruction, i_instr_valid, i_acc_zero,
    output o_operand, o_sel_a, o_sel_b, o_write_acc, o_operacion,
           o_write_ram, o_read_ram, o_addr, o_halted, o_illegal, o_cycle_count
  );

  modport slave (
    output i_instruction, i_instr_valid, i_acc_zero,
    input  o_operand, o_sel_a, o_sel_b, o_write_acc, o_operacion,
           o_write_ram, o_read_ram, o_addr, o_halted, o_illegal, o_cycle_count
  );
endinterface

// File: rtl/bip_decoder.sv
// Combinational opcode decode into a control word.
// Ports: opcode (in, OPCODE_W) -> ctrl (out, ctrl_t).
// Any opcode above JMP is flagged illegal with every strobe at 0.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (32'(opcode))
      32'(OP_HLT):  ctrl.halt = 1'b1;
      32'(OP_STO):  ctrl.write_ram = 1'b1;
      32'(OP_LD): begin
        ctrl.read_ram  = 1'b1;
        ctrl.sel_a     = SEL_A_RAM;
        ctrl.write_acc = 1'b1;
      end
      32'(OP_LDI): begin
        ctrl.sel_a     = SEL_A_OPERAND;
        ctrl.write_acc = 1'b1;
      end
      32'(OP_ADD), 32'(OP_SUB): begin
        ctrl.read_ram  = 1'b1;
        ctrl.sel_b     = 1'b0;
        ctrl.operacion = (32'(opcode) == 32'(OP_ADD));
        ctrl.sel_a     = SEL_A_ALU;
        ctrl.write_acc = 1'b1;
      end
      32'(OP_ADDI), 32'(OP_SUBI): begin
        ctrl.sel_b     = 1'b1;
        ctrl.operacion = (32'(opcode) == 32'(OP_ADDI));
        ctrl.sel_a     = SEL_A_ALU;
        ctrl.write_acc = 1'b1;
      end
      32'(OP_BEQ):  ctrl.pc_kind = PC_BEQ;
      32'(OP_BNE):  ctrl.pc_kind = PC_BNE;
      32'(OP_JMP):  ctrl.pc_kind = PC_JMP;
      default:      ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_control_fsm.sv
// BIP processor control unit: fetches from program memory, issues one
// cycle of datapath strobes per instruction, and sequences the PC.
// Ports: i_clk, i_reset (sync, active-high), bus (master modport):
//   in : i_instruction, i_instr_valid, i_acc_zero
//   out: o_operand, o_sel_a, o_sel_b, o_write_acc, o_operacion,
//        o_write_ram, o_read_ram, o_addr (PC), o_halted, o_illegal,
//        o_cycle_count
//
// state    | meaning
// ST_FETCH | PC on o_addr, strobes 0, wait for i_instr_valid
// ST_EXEC  | one cycle of decoded strobes, PC updated at its end
// ST_HALT  | terminal until reset, strobes 0, PC and count frozen
module bip_control_fsm
  import bip_pkg::*;
#(
  parameter int WORD_W   = 16,
  parameter int OPCODE_W = 5,
  parameter int ADDR_W   = WORD_W - OPCODE_W
) (
  input logic             i_clk,
  input logic             i_reset,
  bip_control_fsm_if.master bus
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ir_operand;
  ctrl_t             ctrl_q;
  ctrl_t             dec;
  logic              halted;
  logic              illegal;
  logic [31:0]       cycle_count;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;

  // Decoding the incoming word during FETCH and registering the result means
  // the EXEC-cycle strobes come straight from flops and match the latched IR.
  bip_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
    .opcode (bus.i_instruction[WORD_W-1 -: OPCODE_W]),
    .ctrl   (dec)
  );

  always_comb begin
    pc_inc  = pc + ADDR_W'(1);
    next_pc = pc_inc;
    case (ctrl_q.pc_kind)
      PC_JMP:  next_pc = ir_operand;
      PC_BEQ:  if (bus.i_acc_zero)  next_pc = ir_operand;
      PC_BNE:  if (!bus.i_acc_zero) next_pc = ir_operand;
      default: next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_FETCH;
      pc          <= '0;
      ir_operand  <= '0;
      ctrl_q      <= CTRL_NOP;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (state != ST_HALT && cycle_count != 32'hFFFF_FFFF)
        cycle_count <= cycle_count + 32'd1;
      case (state)
        ST_FETCH: begin
          if (bus.i_instr_valid) begin
            ir_operand <= bus.i_instruction[ADDR_W-1:0];
            ctrl_q     <= dec;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          ctrl_q <= CTRL_NOP;
          if (ctrl_q.halt || ctrl_q.illegal) begin
            // PC is left on the halting instruction's address.
            state   <= ST_HALT;
            halted  <= 1'b1;
            illegal <= ctrl_q.illegal;
          end else begin
            state <= ST_FETCH;
            pc    <= next_pc;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign bus.o_operand     = ir_operand;
  assign bus.o_sel_a       = ctrl_q.sel_a;
  assign bus.o_sel_b       = ctrl_q.sel_b;
  assign bus.o_write_acc   = ctrl_q.write_acc;
  assign bus.o_operacion   = ctrl_q.operacion;
  assign bus.o_write_ram   = ctrl_q.write_ram;
  assign bus.o_read_ram    = ctrl_q.read_ram;
  assign bus.o_addr        = pc;
  assign bus.o_halted      = halted;
  assign bus.o_illegal     = illegal;
  assign bus.o_cycle_count = cycle_count;

endmodule

// File: tb/tb_bip_control_fsm.sv
// Directed bench for bip_control_fsm (WORD_W=16, ADDR_W=11).
// The driver pushes the hand-computed expected outputs for each clock into a
// queue; the monitor pops one entry per clock just after the edge and compares.
module tb_bip_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bip_control_fsm_if bus ();

  bip_control_fsm dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // {sel_a[1:0], sel_b, write_acc, operacion, write_ram, read_ram}
  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_STO  = 7'b0000010;
  localparam logic [6:0] S_LD   = 7'b0001001;
  localparam logic [6:0] S_LDI  = 7'b0101000;
  localparam logic [6:0] S_ADD  = 7'b1001101;
  localparam logic [6:0] S_ADDI = 7'b1011100;
  localparam logic [6:0] S_SUB  = 7'b1001001;
  localparam logic [6:0] S_SUBI = 7'b1011000;

  typedef struct {
    string       nm;
    logic [6:0]  strb;
    logic [10:0] addr;
    logic [10:0] opnd;
    logic        hlt;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 0;
  logic        prev_halt = 1'b0;
  logic [10:0] cur_pc = 0;
  logic [10:0] cur_opnd = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Drive one clock of inputs and queue what the outputs must be after it.
  task automatic step(input string nm, input logic r, input logic [15:0] ins,
                      input logic vld, input logic az, input logic [6:0] strb,
                      input logic [10:0] addr, input logic [10:0] opnd,
                      input logic hlt, input logic ill);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.i_instruction = ins;
    bus.i_instr_valid = vld;
    bus.i_acc_zero    = az;
    if (r) exp_cnt = 0;
    else if (!prev_halt && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
    prev_halt = hlt;
    e.nm = nm; e.strb = strb; e.addr = addr; e.opnd = opnd;
    e.hlt = hlt; e.ill = ill; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  // Fetch then execute one instruction; valid is held high in EXEC to show
  // it is ignored there.
  task automatic run_instr(input string nm, input logic [15:0] w, input logic az,
                           input logic [6:0] strb, input logic [10:0] nxt);
    logic [10:0] op;
    op = w[10:0];
    step({nm, "_exec"}, 1'b0, w, 1'b1, az, strb, cur_pc, op, 1'b0, 1'b0);
    step({nm, "_next"}, 1'b0, 16'h2801, 1'b1, az, S_NONE, nxt, op, 1'b0, 1'b0);
    cur_pc   = nxt;
    cur_opnd = op;
  endtask

  task automatic do_reset(input string nm);
    step(nm, 1'b1, 16'h2801, 1'b1, 1'b1, S_NONE, 11'h000, 11'h000, 1'b0, 1'b0);
    cur_pc   = 0;
    cur_opnd = 0;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [6:0]  act_strb;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act_strb = {bus.o_sel_a, bus.o_sel_b, bus.o_write_acc, bus.o_operacion,
                    bus.o_write_ram, bus.o_read_ram};
        chk(e.nm, "strobes", 32'(act_strb), 32'(e.strb));
        chk(e.nm, "addr", 32'(bus.o_addr), 32'(e.addr));
        chk(e.nm, "operand", 32'(bus.o_operand), 32'(e.opnd));
        chk(e.nm, "halted", 32'(bus.o_halted), 32'(e.hlt));
        chk(e.nm, "illegal", 32'(bus.o_illegal), 32'(e.ill));
        chk(e.nm, "cycle_count", bus.o_cycle_count, e.cnt);
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    bus.i_instruction = 16'h0000;
    bus.i_instr_valid = 1'b0;
    bus.i_acc_zero    = 1'b0;

    do_reset("rst_a");
    do_reset("rst_b");

    run_instr("addi1", 16'h2801, 1'b0, S_ADDI, 11'h001);
    run_instr("ld3", 16'h1003, 1'b0, S_LD, 11'h002);
    repeat (3) step("idle", 1'b0, 16'h1805, 1'b0, 1'b0, S_NONE, cur_pc, cur_opnd, 1'b0, 1'b0);
    run_instr("ldi5", 16'h1805, 1'b0, S_LDI, 11'h003);
    run_instr("add7", 16'h2007, 1'b0, S_ADD, 11'h004);
    run_instr("sub9", 16'h3009, 1'b0, S_SUB, 11'h005);
    run_instr("jmp7ff", 16'h57FF, 1'b0, S_NONE, 11'h7FF);
    run_instr("addi_wrap", 16'h2801, 1'b0, S_ADDI, 11'h000);
    run_instr("subi2", 16'h3802, 1'b0, S_SUBI, 11'h001);
    run_instr("beq_taken", 16'h4010, 1'b1, S_NONE, 11'h010);
    run_instr("beq_not", 16'h4010, 1'b0, S_NONE, 11'h011);
    run_instr("bne_not", 16'h4810, 1'b1, S_NONE, 11'h012);
    run_instr("bne_taken", 16'h4810, 1'b0, S_NONE, 11'h010);

    // Reset lands on the EXEC cycle of STO.
    step("sto_exec", 1'b0, 16'h0804, 1'b1, 1'b0, S_STO, 11'h010, 11'h004, 1'b0, 1'b0);
    do_reset("sto_rst");

    run_instr("ldi3", 16'h1803, 1'b0, S_LDI, 11'h001);
    run_instr("addi1b", 16'h2801, 1'b0, S_ADDI, 11'h002);
    run_instr("ldi1", 16'h1801, 1'b0, S_LDI, 11'h003);
    step("hlt_exec", 1'b0, 16'h0000, 1'b1, 1'b0, S_NONE, 11'h003, 11'h000, 1'b0, 1'b0);
    step("hlt_enter", 1'b0, 16'h2801, 1'b1, 1'b0, S_NONE, 11'h003, 11'h000, 1'b1, 1'b0);
    repeat (2) step("hlt_hold", 1'b0, 16'h2801, 1'b1, 1'b1, S_NONE, 11'h003, 11'h000, 1'b1, 1'b0);
    do_reset("hlt_rst");

    step("ill_exec", 1'b0, 16'hF805, 1'b1, 1'b0, S_NONE, 11'h000, 11'h005, 1'b0, 1'b0);
    step("ill_enter", 1'b0, 16'h2801, 1'b1, 1'b0, S_NONE, 11'h000, 11'h005, 1'b1, 1'b1);
    repeat (2) step("ill_hold", 1'b0, 16'h2801, 1'b1, 1'b0, S_NONE, 11'h000, 11'h005, 1'b1, 1'b1);
    do_reset("ill_rst");
    run_instr("post_rst", 16'h2801, 1'b0, S_ADDI, 11'h001);

    @(negedge clk);
    rst = 1'b0;
    bus.i_instr_valid = 1'b0;
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip_control_fsm.md
BIP_CONTROL_FSM -- requirements
Module: bip_control_fsm

Interface
REQ-001 Parameter WORD_W, default 16, instruction word width.
REQ-002 Parameter OPCODE_W, default 5, opcode field width (instruction MSBs).
REQ-003 Parameter ADDR_W, default WORD_W-OPCODE_W, operand, program-address and data-address width.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 i_instruction  in  WORD_W  program-memory read data.
REQ-008 i_instr_valid  in  1  i_instruction valid for current o_addr.
REQ-009 i_acc_zero  in  1  accumulator == 0 flag from datapath.
REQ-010 o_operand  out  ADDR_W  operand field of latched instruction.
REQ-011 o_sel_a  out  2  accumulator source: 00 data RAM, 01 operand, 10 ALU.
REQ-012 o_sel_b  out  1  ALU B source: 0 data RAM, 1 operand.
REQ-013 o_write_acc  out  1  accumulator write strobe.
REQ-014 o_operacion  out  1  ALU op: 1 add, 0 subtract.
REQ-015 o_write_ram / o_read_ram  out  1 each  data-RAM strobes.
REQ-016 o_addr  out  ADDR_W  program counter (PC) driven to program memory.
REQ-017 o_halted  out  1  high in HALT state.
REQ-018 o_illegal  out  1  sticky: illegal opcode caused halt.
REQ-019 o_cycle_count  out  32  clock cycles elapsed since reset while not halted.

Function
REQ-020 States: FETCH, EXEC, HALT; encoding is free.
REQ-021 FETCH: o_addr = PC; all strobes 0; on i_instr_valid=1 latch i_instruction into IR, go EXEC; else stay.
REQ-022 EXEC: exactly one cycle; strobes decoded from IR only; PC updated at end; next state FETCH, or HALT for HLT/illegal.
REQ-023 Minimum throughput: 2 cycles per instruction; i_instr_valid during EXEC/HALT ignored.
REQ-024 Opcodes: 00000 HLT, 00001 STO (write_ram), 00010 LD (read_ram, sel_a=00, write_acc), 00011 LDI (sel_a=01, write_acc), 00100 ADD (read_ram, sel_b=0, op=1, sel_a=10, write_acc), 00101 ADDI (sel_b=1, op=1, sel_a=10, write_acc), 00110 SUB (as ADD, op=0), 00111 SUBI (as ADDI, op=0), 01000 BEQ, 01001 BNE, 01010 JMP.
REQ-025 Unused strobes in EXEC are 0; o_sel_a/o_sel_b/o_operacion are 0 when not used.
REQ-026 PC update: JMP -> operand; BEQ -> operand if i_acc_zero=1 (sampled in EXEC) else PC+1; BNE inverse; others PC+1.
REQ-027 PC+1 wraps modulo 2^ADDR_W (all-ones -> 0), no flag.
REQ-028 HLT: enter HALT, PC holds HLT address; o_halted=1 next cycle.
REQ-029 Opcodes 01011..all-ones illegal: no strobes, enter HALT, o_illegal=1.
REQ-030 HALT terminal until i_reset; all strobes 0; o_addr holds.
REQ-031 o_cycle_count increments each cycle in FETCH/EXEC, holds in HALT, saturates at 0xFFFF_FFFF.
REQ-032 o_operand = IR[ADDR_W-1:0] at all times.

Reset
REQ-033 i_reset overrides every other event, including mid-EXEC and HALT.
REQ-034 Reset values: state FETCH, PC 0, IR 0, o_halted 0, o_illegal 0, o_cycle_count 0, all strobes and selects 0.
REQ-035 First fetch from address 0 in the cycle after i_reset deasserts.

Structure
REQ-036 Shared package bip_pkg holds opcode constants, sel_a encodings, state enum.
REQ-037 Sub-module bip_decoder: combinational opcode-to-strobe decode, instantiated once.

Verification (WORD_W=16)
REQ-038 After reset, i_instruction=0x2801 (ADDI 1) valid -> EXEC cycle: sel_b=1, operacion=1, sel_a=10, write_acc=1, operand=1; o_addr 0->1.
REQ-039 JMP 0x7FF (0x57FF) at PC 5 -> next FETCH o_addr=0x7FF; ADDI at 0x7FF -> o_addr wraps to 0.
REQ-040 BEQ 0x010 (0x4010) with i_acc_zero=1 -> o_addr=0x010; with i_acc_zero=0 -> o_addr=PC+1; BNE 0x010 (0x4810) opposite.
REQ-041 i_instr_valid held low 3 cycles in FETCH -> no strobes, o_addr stable, cycle count +3.
REQ-042 0x0000 at PC 3 -> o_halted=1, o_addr=3, count frozen; opcode 11111 -> o_illegal=1; i_reset then clears all.
REQ-043 i_reset asserted during EXEC of STO -> next cycle write_ram=0, o_addr=0, state FETCH.
